// File: rtl/bocks_console_pkg.sv
// Shared constants, state encoding and address helpers for the text console.
package bocks_console_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int CHAR_TOTAL = COLS * ROWS;
    localparam int SCROLL_LEN = COLS * (ROWS - 1);
    localparam int FONT_CHARS = 96;

    localparam int ADDR_W = 11;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 5;
    localparam int DATA_W = 8;

    localparam logic [7:0] FONT_BASE = 8'h20;
    localparam logic [7:0] FONT_LAST = 8'(int'(FONT_BASE) + FONT_CHARS - 1);

    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL,
        FILL
    } console_state_t;

    // Linear character address of a cursor position: row*COLS + col.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // True for bytes that map onto a glyph of the font.
    function automatic logic is_printable(input logic [7:0] code);
        return (code >= FONT_BASE) && (code <= FONT_LAST);
    endfunction

endpackage

// File: rtl/bocks_console_if.sv
// Console bundle: byte-stream handshake, renderer read port and status.
// The producer/renderer side uses master, the console uses slave.
interface bocks_console_if;
    import bocks_console_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              frame_dirty;

    modport master (
        output in_valid, in_data, rd_addr,
        input  in_ready, rd_data, busy, cursor_col, cursor_row, frame_dirty
    );

    modport slave (
        input  in_valid, in_data, rd_addr,
        output in_ready, rd_data, busy, cursor_col, cursor_row, frame_dirty
    );

endinterface

// File: rtl/bocks_char_ram.sv
// CHAR_TOTAL x 8 character RAM. Port A is the console side (one write and
// one registered read per cycle, so a scroll can copy one entry per cycle);
// port B is the renderer's registered read. Reads of an address written in
// the same cycle return the old contents.
module bocks_char_ram
    import bocks_console_pkg::*;
(
    input  logic              pclk,
    input  logic              reset,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] mem [CHAR_TOTAL];

    // Console write and copy-source read.
    // NOTE: the array has no reset; CLEAR defines its contents after power-up.
    always_ff @(posedge pclk) begin
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
        a_rdata <= mem[a_raddr];
    end

    // Renderer read register; only this output flop is reset.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            b_data <= '0;
        end else begin
            b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/bocks_console.sv
// Text console front end: accepts ASCII bytes, tracks the cursor, writes
// font indices into the character RAM and scrolls when the cursor leaves
// the last row.
// Optional feature: define BOCKS_CONSOLE_FF_CLEAR_EN to make form feed
// (0x0C) clear the whole screen; otherwise form feed is ignored.
module bocks_console
    import bocks_console_pkg::*;
(
    input  logic pclk,
    input  logic reset,
    bocks_console_if.slave bus
);

    console_state_t    state;
    logic [ADDR_W-1:0] cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              in_ready_q;
    logic              busy_q;
    logic              dirty_q;

    logic              accept;
    logic              printable;
    logic [COL_W-1:0]  col_nxt;
    logic              nl_req;
    logic              clr_req;

    logic              a_we;
    logic [ADDR_W-1:0] a_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic [ADDR_W-1:0] a_raddr;
    logic [DATA_W-1:0] a_rdata;

    // in_ready is only ever high in IDLE, so accept implies IDLE.
    assign accept    = bus.in_valid && in_ready_q;
    assign printable = is_printable(bus.in_data);

    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.cursor_col  = col;
    assign bus.cursor_row  = row;
    assign bus.frame_dirty = dirty_q;

    // Decode the effect of the current input byte on the cursor.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        col_nxt = col;
        nl_req  = 1'b0;
        clr_req = 1'b0;
        if (printable) begin
            if (col == COL_W'(COLS - 1)) begin
                col_nxt = '0;
                nl_req  = 1'b1;
            end else begin
                col_nxt = col + COL_W'(1);
            end
        end else begin
            case (bus.in_data)
                ASCII_LF: begin
                    col_nxt = '0;
                    nl_req  = 1'b1;
                end
                ASCII_CR: col_nxt = '0;
                ASCII_BS: begin
                    if (col != '0) begin
                        col_nxt = col - COL_W'(1);
                    end
                end
`ifdef BOCKS_CONSOLE_FF_CLEAR_EN
                ASCII_FF: clr_req = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // RAM port A control: clear, print, pipelined scroll copy, last-row fill.
    always_comb begin
        a_we    = 1'b0;
        a_waddr = '0;
        a_wdata = '0;
        // Copy source runs one row ahead of the destination.
        a_raddr = cnt + ADDR_W'(COLS);
        case (state)
            CLEAR: begin
                a_we    = 1'b1;
                a_waddr = cnt;
            end
            IDLE: begin
                if (accept && printable) begin
                    a_we    = 1'b1;
                    a_waddr = lin_addr(row, col);
                    a_wdata = bus.in_data - FONT_BASE;
                end
            end
            SCROLL: begin
                // Step k writes the entry read at step k-1.
                if (cnt != '0) begin
                    a_we    = 1'b1;
                    a_waddr = cnt - ADDR_W'(1);
                    a_wdata = a_rdata;
                end
            end
            FILL: begin
                a_we    = 1'b1;
                a_waddr = ADDR_W'(SCROLL_LEN) + cnt;
            end
            default: ;
        endcase
    end

    // Console FSM with registered handshake, status and cursor outputs.
    // NOTE: state updates use <= so each register sees pre-edge values.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            dirty_q    <= 1'b0;
        end else begin
            dirty_q <= 1'b0;
            case (state)
                CLEAR: begin
                    if (cnt == ADDR_W'(CHAR_TOTAL - 1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        col        <= '0;
                        row        <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        dirty_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        col <= col_nxt;
                        if (printable) begin
                            dirty_q <= 1'b1;
                        end
                        if (clr_req) begin
                            state      <= CLEAR;
                            cnt        <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else if (nl_req) begin
                            if (row == ROW_W'(ROWS - 1)) begin
                                state      <= SCROLL;
                                cnt        <= '0;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end
                    end
                end
                SCROLL: begin
                    // SCROLL_LEN reads plus one trailing write.
                    if (cnt == ADDR_W'(SCROLL_LEN)) begin
                        state <= FILL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                FILL: begin
                    if (cnt == ADDR_W'(COLS - 1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        dirty_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    bocks_char_ram u_ram (
        .pclk    (pclk),
        .reset   (reset),
        .a_we    (a_we),
        .a_waddr (a_waddr),
        .a_wdata (a_wdata),
        .a_raddr (a_raddr),
        .a_rdata (a_rdata),
        .b_addr  (bus.rd_addr),
        .b_data  (bus.rd_data)
    );

endmodule
